// File: rtl/csr_if.sv
// CSR access, trap/return and redirect signals between the execute stage
// and the machine-mode CSR unit.
interface csr_if #(
  parameter int XLEN = 32
);
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            instret_inc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Core (execute stage) side
  modport master (
    output csr_op, csr_addr, csr_wdata, instret_inc,
           trap_valid, trap_cause, trap_pc, mret_valid,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );

  // CSR unit side
  modport slave (
    input  csr_op, csr_addr, csr_wdata, instret_inc,
           trap_valid, trap_cause, trap_pc, mret_valid,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR unit: Zicsr RW/RS/RC accesses, trap entry and mret with
// MIE/MPIE stacking, 64-bit mcycle/minstret counters, fetch redirect target.
// Reads, the illegal flag and the redirect are combinational views of the
// state before the current edge; all updates land on the edge.
module csr_file #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] VENDOR_ID = 32'h79737978,
  parameter logic [31:0] ARCH_ID   = 32'd25040129
) (
  input logic   clk,
  input logic   rst,
  csr_if.slave  bus
);

  localparam bit IS32 = (XLEN == 32);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  // Clears the two low bits of PC-like registers (direct-mode mtvec, mepc).
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  // mstatus as software sees it: MPP fixed at machine mode.
  function automatic logic [XLEN-1:0] mstatus_view(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v        = {XLEN{1'b0}};
    v[12:11] = 2'b11;
    v[7]     = mpie;
    v[3]     = mie;
    return v;
  endfunction

  // Applies per-register write legalisation after the RW/RS/RC operation.
  function automatic logic [XLEN-1:0] legalise(input logic [11:0] addr, input logic [XLEN-1:0] val);
    logic [XLEN-1:0] r;
    case (addr)
      A_MTVEC: r = val & ALIGN_MASK;
      A_MEPC:  r = val & ALIGN_MASK;
      default: r = val;
    endcase
    return r;
  endfunction

  // Architectural state
  logic            mie_r;
  logic            mpie_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
  logic [63:0]     mcycle_r;
  logic [63:0]     minstret_r;

  // Access decode
  logic [XLEN-1:0] old_s;
  logic            impl_s;
  logic            ro_s;
  logic            wr_attempt_s;
  logic            illegal_s;
  logic            wr_en_s;
  logic [XLEN-1:0] wr_val_s;
  logic [XLEN-1:0] lv_s;
  logic [63:0]     wval64_s;
  logic [63:0]     mcycle_nx_s;
  logic [63:0]     minstret_nx_s;

  // Address decode: current value, whether implemented, whether read-only.
  always_comb begin
    old_s  = {XLEN{1'b0}};
    impl_s = 1'b1;
    ro_s   = 1'b0;
    case (bus.csr_addr)
      A_MSTATUS:  old_s = mstatus_view(mie_r, mpie_r);
      A_MTVEC:    old_s = mtvec_r;
      A_MSCRATCH: old_s = mscratch_r;
      A_MEPC:     old_s = mepc_r;
      A_MCAUSE:   old_s = mcause_r;
      A_MCYCLE:   old_s = XLEN'(mcycle_r);
      A_MINSTRET: old_s = XLEN'(minstret_r);
      A_MCYCLEH: begin
        if (IS32) begin
          old_s = XLEN'(mcycle_r[63:32]);
        end else begin
          impl_s = 1'b0;
        end
      end
      A_MINSTRETH: begin
        if (IS32) begin
          old_s = XLEN'(minstret_r[63:32]);
        end else begin
          impl_s = 1'b0;
        end
      end
      A_MVENDORID: begin
        old_s = XLEN'(VENDOR_ID);
        ro_s  = 1'b1;
      end
      A_MARCHID: begin
        old_s = XLEN'(ARCH_ID);
        ro_s  = 1'b1;
      end
      default: impl_s = 1'b0;
    endcase
  end

  // RS/RC with a zero operand are read-only accesses; RW always writes.
  assign wr_attempt_s = (bus.csr_op == OP_RW) ||
                        ((bus.csr_op != OP_NONE) && (bus.csr_wdata != {XLEN{1'b0}}));
  assign illegal_s    = (bus.csr_op != OP_NONE) && (!impl_s || (ro_s && wr_attempt_s));
  // Trap and mret take priority: a coinciding CSR write is discarded whole.
  assign wr_en_s      = wr_attempt_s && !illegal_s && !bus.trap_valid && !bus.mret_valid;

  // Zicsr operation on the pre-edge value.
  always_comb begin
    case (bus.csr_op)
      OP_RW:   wr_val_s = bus.csr_wdata;
      OP_RS:   wr_val_s = old_s | bus.csr_wdata;
      OP_RC:   wr_val_s = old_s & ~bus.csr_wdata;
      default: wr_val_s = old_s;
    endcase
  end

  assign lv_s     = legalise(bus.csr_addr, wr_val_s);
  assign wval64_s = 64'(wr_val_s);

  // Next mcycle: a write to either half replaces it and skips this cycle's increment.
  always_comb begin
    if (wr_en_s && (bus.csr_addr == A_MCYCLE)) begin
      mcycle_nx_s = IS32 ? {mcycle_r[63:32], wval64_s[31:0]} : wval64_s;
    end else if (wr_en_s && (bus.csr_addr == A_MCYCLEH)) begin
      mcycle_nx_s = {wval64_s[31:0], mcycle_r[31:0]};
    end else begin
      mcycle_nx_s = mcycle_r + 64'd1;
    end
  end

  // Next minstret: same write rule, increments only on a retirement.
  always_comb begin
    if (wr_en_s && (bus.csr_addr == A_MINSTRET)) begin
      minstret_nx_s = IS32 ? {minstret_r[63:32], wval64_s[31:0]} : wval64_s;
    end else if (wr_en_s && (bus.csr_addr == A_MINSTRETH)) begin
      minstret_nx_s = {wval64_s[31:0], minstret_r[31:0]};
    end else if (bus.instret_inc) begin
      minstret_nx_s = minstret_r + 64'd1;
    end else begin
      minstret_nx_s = minstret_r;
    end
  end

  // State update: counters every edge, then trap > mret > CSR write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= {XLEN{1'b0}};
      mscratch_r <= {XLEN{1'b0}};
      mepc_r     <= {XLEN{1'b0}};
      mcause_r   <= {XLEN{1'b0}};
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mcycle_r   <= mcycle_nx_s;
      minstret_r <= minstret_nx_s;
      if (bus.trap_valid) begin
        mepc_r   <= bus.trap_pc & ALIGN_MASK;
        mcause_r <= bus.trap_cause;
        mpie_r   <= mie_r;
        mie_r    <= 1'b0;
      end else if (bus.mret_valid) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
      end else if (wr_en_s) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            mie_r  <= lv_s[3];
            mpie_r <= lv_s[7];
          end
          A_MTVEC:    mtvec_r    <= lv_s;
          A_MSCRATCH: mscratch_r <= lv_s;
          A_MEPC:     mepc_r     <= lv_s;
          A_MCAUSE:   mcause_r   <= lv_s;
          default: ;
        endcase
      end else begin
        mie_r <= mie_r;
      end
    end
  end

  assign bus.csr_rdata      = old_s;
  assign bus.csr_illegal    = illegal_s;
  assign bus.redirect_valid = bus.trap_valid | bus.mret_valid;
  assign bus.redirect_pc    = bus.trap_valid ? mtvec_r : mepc_r;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file (XLEN=32): directed vector table, counter/reset
// sequences, then randomized accesses against a behavioural model.
module tb_csr_file;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  csr_if #(.XLEN(32)) bus();
  csr_file #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        trap;
    logic        mret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] e_rdata;
    logic        e_ill;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  bit              m_mie, m_mpie;
  logic [31:0]     m_tvec, m_scr, m_epc, m_cause;
  longint unsigned m_cyc, m_ins;

  logic [11:0] addrs[14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                             12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'h7C0, 12'h301, 12'hB01};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic trap, input logic mret, input logic [31:0] cause,
                       input logic [31:0] pc, input logic inc);
    bus.csr_op      = op;
    bus.csr_addr    = addr;
    bus.csr_wdata   = wdata;
    bus.trap_valid  = trap;
    bus.mret_valid  = mret;
    bus.trap_cause  = cause;
    bus.trap_pc     = pc;
    bus.instret_inc = inc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                              input logic trap, input logic mret, input logic [31:0] cause,
                              input logic [31:0] pc, input logic [31:0] e_rdata, input logic e_ill,
                              input logic e_rv, input logic [31:0] e_rpc);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.trap = trap; v.mret = mret;
    v.cause = cause; v.pc = pc; v.e_rdata = e_rdata; v.e_ill = e_ill; v.e_rv = e_rv; v.e_rpc = e_rpc;
    tbl.push_back(v);
  endfunction

  // Model read: value, implemented flag, read-only flag.
  function automatic void mread(input logic [11:0] a, output logic [31:0] v, output bit impl, output bit ro);
    impl = 1'b1; ro = 1'b0; v = 32'd0;
    case (a)
      12'h300: v = 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h305: v = m_tvec;
      12'h340: v = m_scr;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'hB00: v = 32'(m_cyc);
      12'hB02: v = 32'(m_ins);
      12'hB80: v = 32'(m_cyc >> 32);
      12'hB82: v = 32'(m_ins >> 32);
      12'hF11: begin v = 32'h79737978; ro = 1'b1; end
      12'hF12: begin v = 32'd25040129; ro = 1'b1; end
      default: impl = 1'b0;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] wd, cause, pc, old, nv;
    logic        trap, mret, inc;
    bit          impl, ro, writes, ill, do_wr;
    longint unsigned cyc_n, ins_n;

    //               op     addr     wdata         tr    mr    cause  pc            rdata          ill   rv    rpc
    add(2'd0, 12'hB00, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001800,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'hF11, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h79737978,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'hF12, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd25040129,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'hB00, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd4,         1'b0, 1'b0, 32'd0);
    add(2'd0, 12'hB00, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd5,         1'b0, 1'b0, 32'd0);
    add(2'd1, 12'h305, 32'h80000007, 1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h305, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h80000004,  1'b0, 1'b0, 32'd0);
    add(2'd2, 12'h300, 32'h8,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001800,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001808,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b1, 1'b0, 32'd11, 32'h80000102, 32'h00001808, 1'b0, 1'b1, 32'h80000004);
    add(2'd0, 12'h341, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h80000100,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h342, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd11,        1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b1, 32'd0, 32'd0,        32'h00001880,  1'b0, 1'b1, 32'h80000100);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001888,  1'b0, 1'b0, 32'd0);
    add(2'd3, 12'h300, 32'h8,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001888,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001880,  1'b0, 1'b0, 32'd0);
    add(2'd1, 12'hF11, 32'd5,        1'b0, 1'b0, 32'd0, 32'd0,        32'h79737978,  1'b1, 1'b0, 32'd0);
    add(2'd0, 12'hF11, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h79737978,  1'b0, 1'b0, 32'd0);
    add(2'd2, 12'hF11, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h79737978,  1'b0, 1'b0, 32'd0);
    add(2'd3, 12'hF12, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd25040129,  1'b0, 1'b0, 32'd0);
    add(2'd1, 12'h7C0, 32'd1,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b1, 1'b0, 32'd0);
    add(2'd2, 12'h7C0, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b1, 1'b0, 32'd0);
    add(2'd0, 12'h7C0, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0);
    add(2'd1, 12'h340, 32'h55,       1'b1, 1'b0, 32'd7, 32'h00000200, 32'd0,         1'b0, 1'b1, 32'h80000004);
    add(2'd0, 12'h340, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h341, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00000200,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h342, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd7,         1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001800,  1'b0, 1'b0, 32'd0);
    add(2'd1, 12'h340, 32'hAA,       1'b0, 1'b1, 32'd0, 32'd0,        32'd0,         1'b0, 1'b1, 32'h00000200);
    add(2'd0, 12'h340, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001880,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b1, 1'b1, 32'd3, 32'h00000307, 32'h00001880,  1'b0, 1'b1, 32'h80000004);
    add(2'd0, 12'h341, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00000304,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h300, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00001800,  1'b0, 1'b0, 32'd0);
    add(2'd1, 12'h341, 32'h123,      1'b0, 1'b0, 32'd0, 32'd0,        32'h00000304,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'h341, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'h00000120,  1'b0, 1'b0, 32'd0);
    add(2'd0, 12'hB82, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0,        32'd0,         1'b0, 1'b0, 32'd0);

    // Reset
    rst = 1'b1;
    drive(2'd0, 12'h000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_illegal", bus.csr_illegal, 1'b0);
    check("reset_redirect_valid", bus.redirect_valid, 1'b0);

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].trap, tbl[i].mret, tbl[i].cause, tbl[i].pc, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_rdata", i), bus.csr_rdata, tbl[i].e_rdata);
      check($sformatf("vec%0d_illegal", i), bus.csr_illegal, tbl[i].e_ill);
      check($sformatf("vec%0d_redirect_valid", i), bus.redirect_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) check($sformatf("vec%0d_redirect_pc", i), bus.redirect_pc, tbl[i].e_rpc);
      tick();
    end

    // mcycle wrap: set both halves to all-ones, one more edge wraps to 0
    drive(2'd1, 12'hB00, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    drive(2'd1, 12'hB80, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    drive(2'd0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1 check("mcycle_lo_full", bus.csr_rdata, 32'hFFFFFFFF);
    bus.csr_addr = 12'hB80;
    #1 check("mcycle_hi_full", bus.csr_rdata, 32'hFFFFFFFF);
    tick();
    bus.csr_addr = 12'hB00;
    #1 check("mcycle_lo_wrap", bus.csr_rdata, 32'd0);
    bus.csr_addr = 12'hB80;
    #1 check("mcycle_hi_wrap", bus.csr_rdata, 32'd0);

    // minstret counts three retirements
    drive(2'd0, 12'hB02, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    repeat (3) tick();
    bus.instret_inc = 1'b0;
    #1 check("minstret_3", bus.csr_rdata, 32'd3);
    tick();
    check("minstret_hold", bus.csr_rdata, 32'd3);

    // Asynchronous reset between edges
    drive(2'd1, 12'h340, 32'h55, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    drive(2'd0, 12'h340, 32'd0, 1'b1, 1'b0, 32'd9, 32'h40, 1'b1);
    #1 check("pre_reset_mscratch", bus.csr_rdata, 32'h55);
    rst = 1'b1;
    #1;
    drive(2'd0, 12'h340, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1 check("async_rst_mscratch", bus.csr_rdata, 32'd0);
    bus.csr_addr = 12'h300;
    #1 check("async_rst_mstatus", bus.csr_rdata, 32'h00001800);
    bus.csr_addr = 12'hB00;
    #1 check("async_rst_mcycle", bus.csr_rdata, 32'd0);
    bus.csr_addr = 12'hB02;
    #1 check("async_rst_minstret", bus.csr_rdata, 32'd0);
    check("async_rst_redirect_valid", bus.redirect_valid, 1'b0);
    check("async_rst_illegal", bus.csr_illegal, 1'b0);
    tick();
    rst = 1'b0;

    // Randomized phase against the behavioural model
    m_mie = 1'b0; m_mpie = 1'b0;
    m_tvec = 32'd0; m_scr = 32'd0; m_epc = 32'd0; m_cause = 32'd0;
    m_cyc = 64'd0; m_ins = 64'd0;
    for (int n = 0; n < 600; n++) begin
      a     = addrs[$urandom_range(0, 13)];
      op    = 2'($urandom_range(0, 3));
      wd    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      trap  = ($urandom_range(0, 7) == 0);
      mret  = ($urandom_range(0, 7) == 0);
      cause = 32'($urandom);
      pc    = 32'($urandom);
      inc   = 1'($urandom_range(0, 1));
      drive(op, a, wd, trap, mret, cause, pc, inc);
      @(negedge clk);
      mread(a, old, impl, ro);
      writes = (op == 2'd1) || ((op != 2'd0) && (wd != 32'd0));
      ill    = (op != 2'd0) && (!impl || (ro && writes));
      check("rnd_rdata", bus.csr_rdata, old);
      check("rnd_illegal", bus.csr_illegal, ill);
      check("rnd_redirect_valid", bus.redirect_valid, trap || mret);
      check("rnd_redirect_pc", bus.redirect_pc, trap ? m_tvec : m_epc);

      nv    = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
      do_wr = writes && !ill && !trap && !mret;
      cyc_n = m_cyc + 64'd1;
      ins_n = m_ins + (inc ? 64'd1 : 64'd0);
      if (do_wr) begin
        case (a)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_tvec  = nv & ~32'd3;
          12'h340: m_scr   = nv;
          12'h341: m_epc   = nv & ~32'd3;
          12'h342: m_cause = nv;
          12'hB00: cyc_n   = {m_cyc[63:32], nv};
          12'hB80: cyc_n   = {nv, m_cyc[31:0]};
          12'hB02: ins_n   = {m_ins[63:32], nv};
          12'hB82: ins_n   = {nv, m_ins[31:0]};
          default: ;
        endcase
      end
      if (trap) begin
        m_epc   = pc & ~32'd3;
        m_cause = cause;
        m_mpie  = m_mie;
        m_mie   = 1'b0;
      end else if (mret) begin
        m_mie  = m_mpie;
        m_mpie = 1'b1;
      end
      m_cyc = cyc_n;
      m_ins = ins_n;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
